// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU pipeline writeback, mul/div handshake,
// register-file write port and the pending-destination mask.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pend_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        input  alu_stall, md_ready, we3, wa3, wd3, pend_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        output alu_stall, md_ready, we3, wa3, wd3, pend_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU pipeline and a FIFO-buffered
// mul/div result stream onto the single register-file write port.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             take_alu;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;
    logic [PTR_W-1:0] slot_off;
    logic [31:0]      pend_raw;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = bus.md_valid & ~full;
    // A full FIFO outranks the ALU; an empty one cannot pop, which also
    // keeps a fresh push from bypassing to the port in the same cycle.
    assign pop       = full | (~bus.alu_valid & ~empty);
    assign take_alu  = ~full & bus.alu_valid;
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign bus.md_ready  = ~full;
    assign bus.alu_stall = full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.md_rd;
            fifo_data[wr_ptr] <= bus.md_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // x0 results are consumed without a write; wa3/wd3 keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.we3 <= 1'b0;
            bus.wa3 <= '0;
            bus.wd3 <= '0;
        end else begin
            bus.we3 <= 1'b0;
            if (pop) begin
                if (head_rd != 5'd0) begin
                    bus.we3 <= 1'b1;
                    bus.wa3 <= head_rd;
                    bus.wd3 <= head_data;
                end
            end else if (take_alu) begin
                if (bus.alu_rd != 5'd0) begin
                    bus.we3 <= 1'b1;
                    bus.wa3 <= bus.alu_rd;
                    bus.wd3 <= bus.alu_data;
                end
            end
        end
    end

    // A slot is occupied when its distance from the head is below count.
    always_comb begin
        pend_raw = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr;
            if ({1'b0, slot_off} < count) begin
                pend_raw[fifo_rd[PTR_W'(i)]] = 1'b1;
            end
        end
    end

    assign bus.pend_mask = pend_raw & ~32'h1;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the RISC-V core. It merges two result producers onto the single register-file write port (`we3`/`wa3`/`wd3`):
- the in-order ALU/load pipeline, single-cycle;
- the multi-cycle mul/div unit, valid/ready handshake.

Mul/div results queue in a small FIFO and drain when the pipeline leaves the port idle. A pending-destination mask lets hazard logic stall readers of registers whose mul/div result has not yet been written.

## Interface
Parameters:
- `DEPTH`, default 2: mul/div FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  pipeline has a writeback this cycle.
- `alu_rd`  in  5  pipeline destination register.
- `alu_data`  in  32  pipeline result.
- `alu_stall`  out  1  pipeline must hold its writeback; `alu_valid` is ignored while high.
- `md_valid`  in  1  mul/div result offered.
- `md_ready`  out  1  FIFO can accept; transfer when `md_valid & md_ready`.
- `md_rd`  in  5  mul/div destination.
- `md_data`  in  32  mul/div result.
- `we3`  out  1  register-file write enable (registered).
- `wa3`  out  5  register-file write address (registered).
- `wd3`  out  32  register-file write data (registered).
- `pend_mask`  out  32  bit i set when at least one queued mul/div entry targets xi; bit 0 always 0.

## Operation
- FIFO holds {rd, data}. Internal state: `count` (0..DEPTH), `rd_ptr`, `wr_ptr`, each log2(DEPTH) bits with natural wrap.
- `md_ready = (count != DEPTH)`. Push occurs on `md_valid & md_ready`.
- `alu_stall = (count == DEPTH)`.
- Each cycle, selection for the write port uses this priority:
  1. `count == DEPTH`: pop FIFO head. The ALU is stalled.
  2. else `alu_valid`: the ALU writes.
  3. else `count != 0`: pop FIFO head.
  4. else: no write.
- Push and pop in the same cycle are legal. `count` is unchanged and both pointers advance.
- Push into an empty FIFO is not eligible for pop in the same cycle. No same-cycle bypass through the FIFO; the entry pops one cycle later at the earliest.
- x0 handling: a selected source with rd==0 is consumed (pop or ALU accepted), but `we3` registers 0. x0 entries are queued normally and contribute nothing to `pend_mask`.
- `pend_mask` is combinational, the OR of decoded rd over valid FIFO slots. It excludes an entry popped this cycle only from the next cycle onward.
- Write-after-write ordering: if the ALU and a queued mul/div entry target the same rd, arrival order is not tracked. Hazard logic must stall issue of any instruction whose rd is set in `pend_mask`. The arbiter does no ordering.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `count`, `rd_ptr`, `wr_ptr` = 0.
  - `we3`=0, `wa3`=0, `wd3`=0.
  - `md_ready`=1, `alu_stall`=0, `pend_mask`=0.
  - FIFO data is not reset.
- Reset asserted mid-operation discards all queued entries. No write is emitted for them.
- Latency:
  - ALU: `alu_valid` in cycle N gives `we3`/`wa3`/`wd3` in cycle N+1.
  - Mul/div: accepted in cycle N gives a write no earlier than N+2.
- `we3` is high for exactly one cycle per non-x0 write. `wa3`/`wd3` hold their last value while `we3`=0.
- `alu_stall` and `md_ready` depend only on registered `count`. There is no combinational path from `md_valid` or `alu_valid`.
- Full FIFO with `md_valid`: no push that cycle. The head pops, so `md_ready` is 1 the next cycle.
- Full FIFO with continuous `alu_valid`: the FIFO drains one entry per cycle while full. Once `count < DEPTH`, the ALU resumes priority. The ALU is never starved, because the FIFO can stay full only through cycles of its own popping.

## Test plan
- Reset check: during and after `rst_n` low, all outputs read 0 and `md_ready`=1.
- ALU write: `alu_valid`=1, rd=5, data=0xDEADBEEF in cycle 1 → cycle 2 `we3`=1, `wa3`=5, `wd3`=0xDEADBEEF; cycle 3 `we3`=0.
- Mul/div queue with ALU busy: push rd=7, data=0x12 while `alu_valid`=1 for 3 cycles (rd=1, 2, 3).
  - `pend_mask[7]`=1 until the pop.
  - Writes appear as x1, x2, x3, then x7=0x12 in the first ALU-idle cycle + 1.
  - `pend_mask` is 0 afterwards.
- Full FIFO (DEPTH=2): push rd=8 and rd=9 with `alu_valid` held high.
  - `alu_stall`=1 and `md_ready`=0.
  - Next write is x8. Then `alu_stall`=0 and the ALU write follows before x9.
- x0 drop: ALU rd=0 and mul/div rd=0 accepted → no `we3` pulse; `pend_mask`=0 throughout.
- Simultaneous push/pop: FIFO count=1, push and pop in the same cycle → count stays 1 and FIFO order is preserved. Then assert `rst_n` low mid-queue → no further writes, count=0.
